// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with transaction locking: a grant stays with its owner until done,
// request drop, or a forced revoke after MAX_HOLD consecutive grant cycles.
module rr_lock_arbiter #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state;
    logic [ID_W-1:0]   ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              found;
    logic [ID_W-1:0]   win;
    logic              owner_done;
    logic              owner_gone;
    logic              hold_max;

    // Rotating search: first requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + i) % N);
            end
        end
    end

    assign owner_done = done[gnt_id];
    assign owner_gone = !req[gnt_id];
    assign hold_max   = (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state    <= S_GRANT;
                        gnt      <= {{(N-1){1'b0}}, 1'b1} << win;
                        gnt_id   <= win;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                        ptr      <= (win == ID_W'(N - 1)) ? '0 : win + 1'b1;
                    end
                end
                S_GRANT: begin
                    // Owner's own done/request-drop take precedence over the hold-limit revoke.
                    if (owner_done || owner_gone || hold_max) begin
                        state    <= S_IDLE;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        timeout  <= !owner_done && !owner_gone;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level reference model.
module tb_rr_lock_arbiter;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    done;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            busy;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_lock_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), pointer, cycles held, timeout flag.
    int   m_owner = -1;
    int   m_id    = 0;
    int   m_ptr   = 0;
    int   m_hold  = 0;
    logic m_to    = 1'b0;

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        int  c;
        bit  hit;
        if (r) begin
            m_owner = -1; m_id = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                hit = 0;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!hit && rq[c]) begin
                        hit = 1; m_owner = c; m_id = c; m_hold = 1; m_ptr = (c + 1) % N;
                    end
                end
            end else if (dn[m_owner] || !rq[m_owner]) begin
                m_owner = -1; m_hold = 0;
            end else if (m_hold == MAX_HOLD) begin
                m_owner = -1; m_hold = 0; m_to = 1'b1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic apply(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        reset = r; req = rq; done = dn;
        model_step(r, rq, dn);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] eg, input logic [ID_W-1:0] eid,
                         input logic eb, input logic et);
        n_checks++;
        if ({gnt, gnt_id, busy, timeout} !== {eg, eid, eb, et}) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
                     name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check(name, eg, ID_W'(m_id), (m_owner >= 0), m_to);
    endtask

    task automatic check_invariant();
        n_checks++;
        if (!$onehot0(gnt) || ((gnt != '0) !== busy)) begin
            n_fail++;
            $display("FAIL invariant: got gnt=%b busy=%b, required one-hot-or-zero gnt with busy==(gnt!=0)",
                     gnt, busy);
        end
    endtask

    typedef struct {
        logic            rst;
        logic [N-1:0]    req;
        logic [N-1:0]    done;
        logic [N-1:0]    gnt;
        logic [ID_W-1:0] id;
        logic            busy;
        logic            to;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn,
                       input logic [N-1:0] eg, input logic [ID_W-1:0] eid, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.done = dn; v.gnt = eg; v.id = eid; v.busy = eb; v.to = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        logic            r;
        logic [N-1:0]    rq;
        logic [N-1:0]    dn;

        reset = 1'b1; req = '0; done = '0;

        // Reset with all requesting, then full rotation 0,1,2,3,0 with done in 2nd grant cycle.
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 1, 1);
        add(0, 4'b1111, 4'b0010, 4'b0000, 1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2, 1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2, 1);
        add(0, 4'b1111, 4'b0100, 4'b0000, 2, 0);
        add(0, 4'b1111, 4'b0000, 4'b1000, 3, 1);
        add(0, 4'b1111, 4'b0000, 4'b1000, 3, 1);
        add(0, 4'b1111, 4'b1000, 4'b0000, 3, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 0, 1);
        add(0, 4'b1111, 4'b0001, 4'b0000, 0, 0);

        foreach (tbl[k]) begin
            apply(tbl[k].rst, tbl[k].req, tbl[k].done);
            check($sformatf("table[%0d]", k), tbl[k].gnt, tbl[k].id, tbl[k].busy, tbl[k].to);
        end

        // Single requester never done: exactly MAX_HOLD grant cycles, timeout, regrant.
        apply(0, 4'b0100, 4'b0000); check("hold_grant", 4'b0100, 2, 1, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            apply(0, 4'b0100, 4'b0000); check("hold_held", 4'b0100, 2, 1, 0);
        end
        apply(0, 4'b0100, 4'b0000); check("hold_timeout", 4'b0000, 2, 0, 1);
        apply(0, 4'b0100, 4'b0000); check("hold_regrant", 4'b0100, 2, 1, 0);
        apply(0, 4'b0000, 4'b0000); check("hold_release", 4'b0000, 2, 0, 0);

        // Owner 1 ignores foreign done and other requests; release by req drop goes to 3.
        apply(0, 4'b0010, 4'b0000); check("own1_grant", 4'b0010, 1, 1, 0);
        apply(0, 4'b1011, 4'b1000); check("own1_foreign_done", 4'b0010, 1, 1, 0);
        apply(0, 4'b1001, 4'b0000); check("own1_req_drop", 4'b0000, 1, 0, 0);
        apply(0, 4'b1001, 4'b0000); check("next_is_3", 4'b1000, 3, 1, 0);
        apply(0, 4'b1001, 4'b1000); check("own3_done", 4'b0000, 3, 0, 0);
        apply(0, 4'b0001, 4'b0000); check("next_is_0", 4'b0001, 0, 1, 0);
        apply(0, 4'b0000, 4'b0000); check("own0_drop", 4'b0000, 0, 0, 0);

        // done on the same cycle the hold limit is reached: release without timeout.
        apply(0, 4'b0001, 4'b0000); check("dlim_grant", 4'b0001, 0, 1, 0);
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            apply(0, 4'b0001, 4'b0000); check("dlim_held", 4'b0001, 0, 1, 0);
        end
        apply(0, 4'b0001, 4'b0001); check("dlim_release", 4'b0000, 0, 0, 0);
        apply(0, 4'b0000, 4'b0000); check("dlim_idle", 4'b0000, 0, 0, 0);

        // Reset mid-grant of requester 2; pointer returns to 0 so 1 wins next.
        apply(0, 4'b0100, 4'b0000); check("rst_grant2", 4'b0100, 2, 1, 0);
        apply(0, 4'b0110, 4'b0000); check("rst_hold2", 4'b0100, 2, 1, 0);
        apply(1, 4'b0110, 4'b0000); check("rst_mid_grant", 4'b0000, 0, 0, 0);
        apply(0, 4'b0110, 4'b0000); check("rst_then_1", 4'b0010, 1, 1, 0);
        apply(0, 4'b0000, 4'b0000); check("rst_drop", 4'b0000, 1, 0, 0);

        // Random traffic: sticky requests, sparse done strobes, rare resets.
        rq = '0;
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 299) == 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
                dn[b] = ($urandom_range(0, 15) == 0);
            end
            apply(r, rq, dn);
            check_model($sformatf("random[%0d]", c));
            check_invariant();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
